// File: rtl/hpdmc_refresh_sched.sv
// Auto-refresh scheduler: interval timer, refresh debt counter, PRECHARGE ALL + AUTO REFRESH sequencer.
// Latency: grant seen in cycle N -> PRECHARGE in N+1, REFRESH in N+1+tRP, ref_done in N+1+tRP+tRFC.
// Backpressure: refreshes owed while no grant accumulate as debt; once started a sequence ignores grant.
// Config macro HPDMC_REFRESH_POSTPONE_EN: when defined debt saturates at MAX_DEBT, else at 1.
module hpdmc_refresh_sched #(
  parameter int unsigned MAX_DEBT    = 8,
  parameter int unsigned URGENT_DEBT = 6
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        sdram_rst,
  input  logic [10:0] tim_refi,
  input  logic [2:0]  tim_rp,
  input  logic [3:0]  tim_rfc,
  output logic        ref_req,
  output logic        ref_urgent,
  input  logic        ref_grant,
  output logic        ref_busy,
  output logic        ref_done,
  output logic        ref_cs_n,
  output logic        ref_ras_n,
  output logic        ref_cas_n,
  output logic        ref_we_n,
  output logic        ref_a10,
  output logic [3:0]  ref_debt,
  output logic        ref_overflow
);

`ifdef HPDMC_REFRESH_POSTPONE_EN
  localparam bit POSTPONE = 1'b1;
`else
  localparam bit POSTPONE = 1'b0;
`endif

  // Without postponement only a single owed refresh can be held.
  localparam logic [3:0] DEBT_MAX   = POSTPONE ? 4'(MAX_DEBT) : 4'd1;
  localparam logic [3:0] URGENT_LVL = 4'(URGENT_DEBT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_REF,
    S_WAIT_RFC,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] refi_cnt_q, refi_cnt_d;
  logic [3:0]  debt_q, debt_d;
  logic        ovf_q, ovf_d;
  logic        req_q, req_d;
  logic        urgent_q, urgent_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cs_n_q, cs_n_d;
  logic        ras_n_q, ras_n_d;
  logic        cas_n_q, cas_n_d;
  logic        we_n_q, we_n_d;
  logic        a10_q, a10_d;
  logic [2:0]  rp_q, rp_d;
  logic [3:0]  rfc_q, rfc_d;
  logic [3:0]  wait_q, wait_d;
  logic        tick;

  // Interval counter: counts tim_refi down to 0, ticks at 0 and reloads (tim_refi=0 ticks every cycle).
  always_comb begin
    tick       = !sdram_rst && (refi_cnt_q == 11'd0);
    refi_cnt_d = refi_cnt_q - 11'd1;
    if (sdram_rst || tick) begin
      refi_cnt_d = tim_refi;
    end
  end

  // Debt bookkeeping: tick adds, ref_done removes, both together cancel; saturation flags overflow.
  always_comb begin
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (sdram_rst) begin
      debt_d = 4'd0;
      ovf_d  = 1'b0;
    end else begin
      if (tick && (debt_q >= DEBT_MAX)) begin
        ovf_d = 1'b1;
      end
      if (tick && !done_q && (debt_q < DEBT_MAX)) begin
        debt_d = debt_q + 4'd1;
      end else if (done_q && !tick && (debt_q != 4'd0)) begin
        debt_d = debt_q - 4'd1;
      end
    end
    req_d    = (debt_d != 4'd0);
    urgent_d = POSTPONE ? (debt_d >= URGENT_LVL) : req_d;
  end

  // Sequencer next state; wait counters hold remaining NOP cycles minus one.
  always_comb begin
    state_d = state_q;
    rp_d    = rp_q;
    rfc_d   = rfc_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (req_q && ref_grant) begin
          state_d = S_PRE;
          rp_d    = (tim_rp == 3'd0) ? 3'd1 : tim_rp;
          rfc_d   = (tim_rfc == 4'd0) ? 4'd1 : tim_rfc;
        end
      end
      S_PRE: begin
        if (rp_q == 3'd1) begin
          state_d = S_REF;
        end else begin
          state_d = S_WAIT_RP;
          wait_d  = {1'b0, rp_q} - 4'd2;
        end
      end
      S_WAIT_RP: begin
        if (wait_q == 4'd0) begin
          state_d = S_REF;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_REF: begin
        if (rfc_q == 4'd1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_RFC;
          wait_d  = rfc_q - 4'd2;
        end
      end
      S_WAIT_RFC: begin
        if (wait_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (sdram_rst) begin
      state_d = S_IDLE;
    end
  end

  // Outputs are decoded from the next state so that they appear registered in the state they belong to.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    cs_n_d  = 1'b1;
    ras_n_d = 1'b1;
    cas_n_d = 1'b1;
    we_n_d  = 1'b1;
    a10_d   = 1'b0;
    if (state_d == S_PRE) begin
      cs_n_d  = 1'b0;
      ras_n_d = 1'b0;
      we_n_d  = 1'b0;
      a10_d   = 1'b1;
    end else if (state_d == S_REF) begin
      cs_n_d  = 1'b0;
      ras_n_d = 1'b0;
      cas_n_d = 1'b0;
    end
  end

  // All state and outputs registered, synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      refi_cnt_q <= tim_refi;
      debt_q     <= 4'd0;
      ovf_q      <= 1'b0;
      req_q      <= 1'b0;
      urgent_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      ras_n_q    <= 1'b1;
      cas_n_q    <= 1'b1;
      we_n_q     <= 1'b1;
      a10_q      <= 1'b0;
      rp_q       <= 3'd1;
      rfc_q      <= 4'd1;
      wait_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      refi_cnt_q <= refi_cnt_d;
      debt_q     <= debt_d;
      ovf_q      <= ovf_d;
      req_q      <= req_d;
      urgent_q   <= urgent_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      ras_n_q    <= ras_n_d;
      cas_n_q    <= cas_n_d;
      we_n_q     <= we_n_d;
      a10_q      <= a10_d;
      rp_q       <= rp_d;
      rfc_q      <= rfc_d;
      wait_q     <= wait_d;
    end
  end

  assign ref_req      = req_q;
  assign ref_urgent   = urgent_q;
  assign ref_busy     = busy_q;
  assign ref_done     = done_q;
  assign ref_cs_n     = cs_n_q;
  assign ref_ras_n    = ras_n_q;
  assign ref_cas_n    = cas_n_q;
  assign ref_we_n     = we_n_q;
  assign ref_a10      = a10_q;
  assign ref_debt     = debt_q;
  assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_hpdmc_refresh_sched.sv
// Bench for hpdmc_refresh_sched: absolute-cycle reference model checked every cycle plus directed literal checks.
// Inputs change 1 time unit after the rising edge; outputs compared on the falling edge.
module tb_hpdmc_refresh_sched;

`ifdef HPDMC_REFRESH_POSTPONE_EN
  localparam int MAXD = 8;
  localparam bit PP   = 1'b1;
`else
  localparam int MAXD = 1;
  localparam bit PP   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sdram_rst;
  logic [10:0] tim_refi;
  logic [2:0]  tim_rp;
  logic [3:0]  tim_rfc;
  logic        grant;
  logic        ref_req, ref_urgent, ref_busy, ref_done;
  logic        ref_cs_n, ref_ras_n, ref_cas_n, ref_we_n, ref_a10;
  logic [3:0]  ref_debt;
  logic        ref_overflow;

  int n_pass  = 0;
  int n_total = 0;

  hpdmc_refresh_sched #(.MAX_DEBT(8), .URGENT_DEBT(6)) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .sdram_rst   (sdram_rst),
    .tim_refi    (tim_refi),
    .tim_rp      (tim_rp),
    .tim_rfc     (tim_rfc),
    .ref_req     (ref_req),
    .ref_urgent  (ref_urgent),
    .ref_grant   (grant),
    .ref_busy    (ref_busy),
    .ref_done    (ref_done),
    .ref_cs_n    (ref_cs_n),
    .ref_ras_n   (ref_ras_n),
    .ref_cas_n   (ref_cas_n),
    .ref_we_n    (ref_we_n),
    .ref_a10     (ref_a10),
    .ref_debt    (ref_debt),
    .ref_overflow(ref_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: ticks and sequence phases tracked as absolute cycle numbers.
  int cyc       = 0;
  int next_tick = 0;
  int m_debt    = 0;
  bit m_ovf     = 1'b0;
  int start     = -1000;
  int lrp       = 1;
  int lrfc      = 1;
  bit e_pre = 1'b0, e_ref = 1'b0, e_done = 1'b0, e_busy = 1'b0, e_req = 1'b0, e_urg = 1'b0;
  bit model_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk_cmd(input string tag, input int cs, input int ras, input int cas, input int we, input int a10);
    chk({tag, "_cs_n"}, int'(ref_cs_n), cs);
    chk({tag, "_ras_n"}, int'(ref_ras_n), ras);
    chk({tag, "_cas_n"}, int'(ref_cas_n), cas);
    chk({tag, "_we_n"}, int'(ref_we_n), we);
    chk({tag, "_a10"}, int'(ref_a10), a10);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin : model
    bit tick;
    if (!rst_n || sdram_rst) begin
      next_tick = cyc + 1 + int'(tim_refi);
      m_debt    = 0;
      m_ovf     = 1'b0;
      start     = -1000;
    end else begin
      tick = (cyc == next_tick);
      if (tick) next_tick = cyc + 1 + int'(tim_refi);
      if (tick && m_debt == MAXD) m_ovf = 1'b1;
      if (tick && !e_done && m_debt < MAXD) m_debt++;
      else if (e_done && !tick) m_debt--;
      if (!e_busy && e_req && grant) begin
        start = cyc + 1;
        lrp   = (tim_rp == 0) ? 1 : int'(tim_rp);
        lrfc  = (tim_rfc == 0) ? 1 : int'(tim_rfc);
      end
    end
    cyc++;
    e_pre  = (cyc == start);
    e_ref  = (cyc == start + lrp);
    e_done = (cyc == start + lrp + lrfc);
    e_busy = (cyc >= start) && (cyc <= start + lrp + lrfc);
    e_req  = (m_debt != 0);
    e_urg  = PP ? (m_debt >= 6) : e_req;
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("cs_n", int'(ref_cs_n), int'(!(e_pre || e_ref)));
      chk("ras_n", int'(ref_ras_n), int'(!(e_pre || e_ref)));
      chk("cas_n", int'(ref_cas_n), int'(!e_ref));
      chk("we_n", int'(ref_we_n), int'(!e_pre));
      chk("a10", int'(ref_a10), int'(e_pre));
      chk("busy", int'(ref_busy), int'(e_busy));
      chk("done", int'(ref_done), int'(e_done));
      chk("req", int'(ref_req), int'(e_req));
      chk("urgent", int'(ref_urgent), int'(e_urg));
      chk("debt", int'(ref_debt), m_debt);
      chk("overflow", int'(ref_overflow), int'(m_ovf));
    end
  end

  initial begin
    int x, n, y, z, w;
    bit found;
    rst_n     = 1'b0;
    sdram_rst = 1'b1;
    tim_refi  = 11'd10;
    tim_rp    = 3'd2;
    tim_rfc   = 4'd6;
    grant     = 1'b0;

    // Reset values
    step(1);
    chk_cmd("rst", 1, 1, 1, 1, 0);
    chk("rst_req", int'(ref_req), 0);
    chk("rst_busy", int'(ref_busy), 0);
    chk("rst_done", int'(ref_done), 0);
    chk("rst_debt", int'(ref_debt), 0);
    chk("rst_ovf", int'(ref_overflow), 0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Single refresh; grant dropped during WAIT_RP
    sdram_rst = 1'b0;
    x = cyc;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1);
      if (ref_req) found = 1'b1;
    end
    chk("req_timeout", int'(found), 1);
    chk("first_tick_delay", cyc - x, 11);
    n = cyc;
    grant = 1'b1;
    step(1);
    chk_cmd("pre", 0, 0, 1, 0, 1);
    step(1);
    grant = 1'b0;
    chk("wait_rp_busy", int'(ref_busy), 1);
    chk_cmd("wait_rp", 1, 1, 1, 1, 0);
    step(1);
    chk("ref_cycle", cyc - n, 3);
    chk_cmd("ref", 0, 0, 0, 1, 0);
    step(2);
    chk("wait_rfc_busy", int'(ref_busy), 1);
    step(4);
    chk("done_pulse", int'(ref_done), 1);
    step(1);
    chk("after_busy", int'(ref_busy), 0);
    chk("after_done", int'(ref_done), 0);
    chk("after_debt", int'(ref_debt), 0);

    // Postponement: tim_refi=4, no grant
    sdram_rst = 1'b1;
    tim_refi  = 11'd4;
    step(1);
    sdram_rst = 1'b0;
    x = cyc;
    step(30);
    chk("pp_debt6", int'(ref_debt), PP ? 6 : 1);
    chk("pp_urgent", int'(ref_urgent), 1);
    step(10);
    chk("pp_debt8", int'(ref_debt), PP ? 8 : 1);
    chk("pp_ovf_early", int'(ref_overflow), PP ? 0 : 1);
    step(5);
    chk("pp_ovf_late", int'(ref_overflow), 1);
    chk("pp_debt_sat", int'(ref_debt), MAXD);

    // Tick landing on the DONE cycle
    sdram_rst = 1'b1;
    tim_refi  = 11'd5;
    tim_rp    = 3'd1;
    tim_rfc   = 4'd3;
    step(1);
    sdram_rst = 1'b0;
    y = cyc;
    step(12);
    chk("td_req", int'(ref_req), 1);
    grant = 1'b1;
    step(1);
    grant = 1'b0;
    chk_cmd("td_pre", 0, 0, 1, 0, 1);
    step(1);
    chk_cmd("td_ref", 0, 0, 0, 1, 0);
    step(3);
    chk("td_cycle", cyc - y, 17);
    chk("td_done", int'(ref_done), 1);
    chk("td_debt_pre", int'(ref_debt), PP ? 2 : 1);
    step(1);
    chk("td_debt_post", int'(ref_debt), PP ? 2 : 1);

    // sdram_rst during WAIT_RFC
    tim_rp  = 3'd2;
    tim_rfc = 4'd6;
    z = cyc;
    grant = 1'b1;
    step(1);
    grant = 1'b0;
    step(4);
    sdram_rst = 1'b1;
    step(1);
    sdram_rst = 1'b0;
    chk("sr_cycle", cyc - z, 6);
    chk_cmd("sr_nop", 1, 1, 1, 1, 0);
    chk("sr_busy", int'(ref_busy), 0);
    chk("sr_debt", int'(ref_debt), 0);
    chk("sr_ovf", int'(ref_overflow), 0);
    chk("sr_done", int'(ref_done), 0);
    step(3);
    chk("sr_no_done", int'(ref_done), 0);
    step(2);
    chk("sr_req_early", int'(ref_req), 0);
    step(1);
    chk("sr_req_tick", int'(ref_req), 1);

    // tim_refi = 0 ticks every cycle
    sdram_rst = 1'b1;
    tim_refi  = 11'd0;
    step(1);
    sdram_rst = 1'b0;
    w = cyc;
    step(3);
    chk("z_cycle", cyc - w, 3);
    chk("z_debt", int'(ref_debt), PP ? 3 : 1);
    chk("z_ovf", int'(ref_overflow), PP ? 0 : 1);
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
